// File: rtl/data_ram_ctl.sv
// Byte-lane-writable single-port data RAM with a clear sequencer that zeroes
// every word after reset or on request before requests are served again.
module data_ram_ctl #(
    parameter int D = 8,
    parameter int W = 8,
    localparam int L = W / 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    output logic         busy,
    input  logic         req_valid,
    input  logic         req_write,
    input  logic [D-1:0] req_addr,
    input  logic [W-1:0] req_din,
    input  logic [L-1:0] req_be,
    output logic         req_ready,
    output logic         rsp_valid,
    output logic [W-1:0] rsp_dout
);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t       state;
    logic [D-1:0] counter;
    logic [W-1:0] mem [0:(1<<D)-1];
    logic         accept;
    logic         accept_read;
    logic         accept_write;

    assign req_ready    = (state == IDLE);
    assign busy         = (state == CLEAR);
    assign accept       = req_valid && req_ready;
    assign accept_read  = accept && !req_write;
    assign accept_write = accept && req_write;

    // A request accepted on the same edge as clear still completes; the
    // sequencer only starts zeroing from the next edge onward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            counter   <= '0;
            rsp_valid <= 1'b0;
            rsp_dout  <= '0;
        end else begin
            rsp_valid <= accept_read;
            if (accept_read) begin
                rsp_dout <= mem[req_addr];
            end
            case (state)
                CLEAR: begin
                    counter <= counter + 1'b1;
                    if (counter == '1) begin
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (clear) begin
                        state   <= CLEAR;
                        counter <= '0;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    counter <= '0;
                end
            endcase
        end
    end

    // Storage has no reset; only the sequencer is allowed to zero it.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[counter] <= '0;
        end else if (accept_write) begin
            for (int i = 0; i < L; i++) begin
                if (req_be[i]) begin
                    mem[req_addr][8*i +: 8] <= req_din[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_ctl.sv
// Scoreboard bench for data_ram_ctl (D=4, W=16): a cycle model tracks the
// clear sequencer and memory, expected read data is queued and popped on response.
module tb_data_ram_ctl;

    localparam int D = 4;
    localparam int W = 16;
    localparam int L = 2;
    localparam int DEPTH = 1 << D;

    logic         clk;
    logic         rst_n;
    logic         clear;
    logic         busy;
    logic         req_valid;
    logic         req_write;
    logic [D-1:0] req_addr;
    logic [W-1:0] req_din;
    logic [L-1:0] req_be;
    logic         req_ready;
    logic         rsp_valid;
    logic [W-1:0] rsp_dout;

    data_ram_ctl #(.D(D), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .busy      (busy),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_din   (req_din),
        .req_be    (req_be),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_dout  (rsp_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;
    logic [W-1:0] model_mem [DEPTH];
    int          clear_left;
    logic [W-1:0] last_dout;
    logic [W-1:0] rsp_q [$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compares every observable output against the model just after an edge.
    task automatic checkCycle();
        logic [W-1:0] exp;
        checkOutput("busy", busy, clear_left > 0);
        checkOutput("req_ready", req_ready, clear_left == 0);
        if (rsp_q.size() > 0) begin
            exp = rsp_q.pop_front();
            checkOutput("rsp_valid", rsp_valid, 1);
            checkOutput("rsp_dout", rsp_dout, exp);
            last_dout = exp;
        end else begin
            checkOutput("rsp_valid_idle", rsp_valid, 0);
            checkOutput("rsp_dout_hold", rsp_dout, last_dout);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic w, input logic [D-1:0] a,
                                 input logic [W-1:0] d, input logic [L-1:0] b, input logic c);
        logic accepted;
        req_valid = v;
        req_write = w;
        req_addr  = a;
        req_din   = d;
        req_be    = b;
        clear     = c;
        accepted  = v && (clear_left == 0) && rst_n;
        @(posedge clk);
        if (rst_n) begin
            if (clear_left > 0) begin
                clear_left--;
            end else begin
                if (accepted && !w) rsp_q.push_back(model_mem[a]);
                if (accepted && w) begin
                    for (int i = 0; i < L; i++)
                        if (b[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
                end
                if (c) begin
                    clear_left = DEPTH;
                    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
                end
            end
        end
        #1;
        checkCycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, '0, 0);
    endtask

    task automatic wr(input logic [D-1:0] a, input logic [W-1:0] d, input logic [L-1:0] b);
        applyStimulus(1, 1, a, d, b, 0);
    endtask

    task automatic rd(input logic [D-1:0] a);
        applyStimulus(1, 0, a, '0, '0, 0);
    endtask

    task automatic assertReset();
        rst_n = 1'b0;
        clear_left = DEPTH;
        rsp_q.delete();
        last_dout = '0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        #1;
        checkOutput("rst_busy", busy, 1);
        checkOutput("rst_ready", req_ready, 0);
        checkOutput("rst_rsp_valid", rsp_valid, 0);
        checkOutput("rst_rsp_dout", rsp_dout, 0);
    endtask

    initial begin
        clear = 0; req_valid = 0; req_write = 0; req_addr = '0; req_din = '0; req_be = '0;
        rst_n = 1'b1;
        #2;
        assertReset();
        idle(3);
        rst_n = 1'b1;
        #1;
        checkOutput("post_release_busy", busy, 1);

        // Post-reset clear: exactly 16 busy cycles, then every word reads zero.
        idle(DEPTH);
        for (int i = 0; i < DEPTH; i++) rd(i[D-1:0]);
        idle(1);

        // Lane merge: full write, then low-lane overwrite.
        wr(4'd3, 16'hABCD, 2'b11);
        wr(4'd3, 16'h1234, 2'b01);
        rd(4'd3);
        idle(1);

        // Back-to-back reads, then rsp_dout must hold with rsp_valid low.
        wr(4'd1, 16'h0011, 2'b11);
        wr(4'd2, 16'h0022, 2'b11);
        wr(4'd3, 16'h0033, 2'b11);
        rd(4'd1);
        rd(4'd2);
        rd(4'd3);
        idle(3);

        // All-zero byte enables leave memory untouched.
        wr(4'd7, 16'h7777, 2'b11);
        wr(4'd7, 16'hFFFF, 2'b00);
        rd(4'd7);
        idle(1);

        // Read shares an edge with clear; a second clear mid-run is ignored,
        // and a read held during clear is not accepted.
        wr(4'd5, 16'h5555, 2'b11);
        applyStimulus(1, 0, 4'd5, '0, '0, 1);
        idle(7);
        applyStimulus(0, 0, '0, '0, '0, 1);
        rd(4'd9);
        idle(6);
        idle(2);
        rd(4'd5);
        idle(1);

        // Reset asserted mid-clear restarts the full sequence after release.
        wr(4'd6, 16'h6666, 2'b11);
        applyStimulus(0, 0, '0, '0, '0, 1);
        idle(10);
        assertReset();
        idle(2);
        rst_n = 1'b1;
        #1;
        checkOutput("mid_clear_release_busy", busy, 1);
        idle(DEPTH + 2);
        rd(4'd6);
        idle(1);

        // Mixed random traffic with occasional clears.
        for (int n = 0; n < 300; n++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          D'($urandom_range(0, DEPTH - 1)), W'($urandom),
                          L'($urandom_range(0, 3)), $urandom_range(0, 59) == 0);
        end
        idle(DEPTH + 2);

        checkOutput("rsp_pending", rsp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_ram_ctl.md
DATA_RAM_CTL -- requirements
Module: data_ram_ctl

Interface
REQ-001 Parameter D, default 8, address width; memory depth SHALL be 2**D words.
REQ-002 Parameter W, default 8, data width; SHALL be a multiple of 8, giving lanes L = W/8.
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  request to zero the whole memory.
REQ-006 busy  output  1  high while the clear sequencer runs.
REQ-007 req_valid  input  1  request present.
REQ-008 req_write  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  D  word address.
REQ-010 req_din  input  W  write data.
REQ-011 req_be  input  L  byte-lane write enables; bit i covers data bits [8i+7:8i].
REQ-012 req_ready  output  1  block can accept a request this cycle.
REQ-013 rsp_valid  output  1  read data valid.
REQ-014 rsp_dout  output  W  registered read data.

Function
REQ-015 The block SHALL have two states: CLEAR (sequencer writing zeros) and IDLE (serving requests).
REQ-016 A request SHALL be accepted on a rising edge where req_valid && req_ready; at most one request per cycle.
REQ-017 req_ready SHALL equal (state == IDLE), combinationally.
REQ-018 busy SHALL equal (state == CLEAR).
REQ-019 An accepted write SHALL update only lanes whose req_be bit is 1, at that edge; other lanes keep their contents.
REQ-020 An accepted write with req_be all zero SHALL be accepted and SHALL leave memory unchanged.
REQ-021 An accepted read SHALL load rsp_dout with M[req_addr] at that edge, and rsp_valid SHALL be 1 for exactly the following cycle.
REQ-022 rsp_valid SHALL be 0 in every cycle not following an accepted read.
REQ-023 rsp_dout SHALL hold its last value when rsp_valid is 0; it is never driven hi-Z.
REQ-024 A read accepted the cycle after a write to the same address SHALL return the newly written lanes merged with the unchanged lanes.
REQ-025 In CLEAR, an internal counter of D bits SHALL start at 0, write zero to M[counter] each cycle, and increment.
REQ-026 After the cycle that writes address 2**D-1, the state SHALL become IDLE; a clear SHALL therefore last exactly 2**D cycles.
REQ-027 clear sampled high in IDLE SHALL move the block to CLEAR with counter 0 on the next edge.
REQ-028 clear sampled high during CLEAR SHALL be ignored; the clear in progress neither restarts nor extends.
REQ-029 When clear and an accepted request share an edge in IDLE, the request SHALL complete normally (including any read response), and CLEAR SHALL begin on that edge.
REQ-030 Requests presented during CLEAR SHALL not be accepted; the requester holds them until req_ready is 1.

Reset
REQ-031 While rst_n is 0: state = CLEAR, counter = 0, rsp_valid = 0, rsp_dout = 0, busy = 1, req_ready = 0, with no clock required.
REQ-032 On rst_n deassertion, the post-reset clear SHALL run from address 0 for 2**D cycles and then enter IDLE.
REQ-033 rst_n assertion in the middle of a clear SHALL abort it; the clear restarts from address 0 after release.
REQ-034 Memory contents SHALL not be reset asynchronously; only the sequencer zeroes them.

Verification (D=4, W=16, L=2)
REQ-035 Release rst_n -> busy = 1 and req_ready = 0 for exactly 16 cycles, then busy = 0 and req_ready = 1; reads of all 16 addresses return 0x0000.
REQ-036 In IDLE, write 0xABCD to address 3 with be = 2'b11, then write 0x1234 to address 3 with be = 2'b01, then read address 3 -> rsp_valid high one cycle later, rsp_dout = 0xAB34.
REQ-037 Back-to-back reads of addresses 1, 2, 3 holding 0x0011, 0x0022, 0x0033 -> rsp_valid high for 3 consecutive cycles with rsp_dout 0x0011, 0x0022, 0x0033; rsp_dout holds 0x0033 afterwards with rsp_valid = 0.
REQ-038 Pulse clear together with an accepted read of address 5 holding 0x5555 -> next cycle rsp_valid = 1 with 0x5555 and busy = 1; busy stays high 16 cycles; a second clear pulse at cycle 8 does not extend it; address 5 then reads 0x0000.
REQ-039 Assert rst_n low at clear cycle 10, then release -> busy remains high a further 16 cycles after release; rsp_valid = 0 throughout.
REQ-040 Write with be = 2'b00 to address 7 holding 0x7777 -> request accepted; a subsequent read of address 7 returns 0x7777.
